serial_sub_ctrl: RTL and testbench

Bit-serial subtraction controller that computes A − B over WIDTH clock cycles by sequencing a single one-bit subtractor cell (two half subtractors plus borrow OR) with a registered borrow. It accepts parallel operands with a start/busy/done handshake, shifts them LSB-first through the shared cell, and presents a parallel difference and a final borrow. It is the sequencing layer above the half-subtractor datapath, trading area for latency in multi-bit subtraction.

---
 rtl/serial_sub_if.sv | 15 +
 rtl/serial_sub_ctrl.sv | 115 +++++++++++
 tb/tb_serial_sub_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor controller.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (output start, a, b, input busy, done, diff, bout);
    modport slave  (input start, a, b, output busy, done, diff, bout);
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A-B controller: one subtractor cell, LSB first, WIDTH cycles per result.
// Define SERIAL_SUB_SAT_EN to clamp diff to zero whenever the final borrow is set.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit per edge through the shared cell
// DONE  | done pulse; results valid; may accept a new start
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             d_bit;
    logic             b_next;

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        diff_sr_d = diff_sr_q;
        diff_d    = diff_q;
        cnt_d     = cnt_q;
        br_d      = br_q;
        bout_d    = bout_q;
        d_bit     = 1'b0;
        b_next    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_sr_d    = bus.a;
                    b_sr_d    = bus.b;
                    diff_sr_d = '0;
                    br_d      = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_RUN;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_RUN: begin
                // Two half subtractors plus borrow OR, operating on bit 0.
                d_bit  = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
                b_next = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                diff_sr_d = diff_sr_q >> 1;
                diff_sr_d[WIDTH-1] = d_bit;
                br_d   = b_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
`ifdef SERIAL_SUB_SAT_EN
                    diff_d = b_next ? '0 : diff_sr_d;
`else
                    diff_d = diff_sr_d;
`endif
                    bout_d  = b_next;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            diff_sr_q <= '0;
            diff_q    <= '0;
            cnt_q     <= '0;
            br_q      <= 1'b0;
            bout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            diff_sr_q <= diff_sr_d;
            diff_q    <= diff_d;
            cnt_q     <= cnt_d;
            br_q      <= br_d;
            bout_q    <= bout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: directed operands, monitor checks each done pulse.
module tb_serial_sub_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_sub_if #(.WIDTH(W)) bus ();
    serial_sub_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        int           c;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.busy && bus.done) begin
                n_cmp++;
                n_err++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b cycle %0d", bus.busy, bus.done, cyc);
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_done: got done=1 want none at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    check("diff", 32'(bus.diff), 32'(e.d));
                    check("bout", 32'(bus.bout), 32'(e.bo));
                    check("done_cycle", cyc, e.c);
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb, input bit push,
                         output int k);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = av;
        bus.b = bv;
        @(posedge clk);
        #1;
        k = cyc;
        if (push) sb.push_back('{ed, eb, k + W});
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);

        // Basic operation with busy/done timing inside the run
        issue(8'h5A, 8'h23, 8'h37, 1'b0, 1'b1, k);
        while (cyc < k + W - 1) @(negedge clk);
        check("run_busy_last", 32'(bus.busy), 32'd1);
        check("run_done_low", 32'(bus.done), 32'd0);
        check("run_diff_held", 32'(bus.diff), 32'd0);
        drain();
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);

        // Borrow case
`ifdef SERIAL_SUB_SAT_EN
        issue(8'h10, 8'h20, 8'h00, 1'b1, 1'b1, k);
`else
        issue(8'h10, 8'h20, 8'hF0, 1'b1, 1'b1, k);
`endif
        drain();

        // Equal operands, then smallest underflow
        issue(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, k);
        drain();
`ifdef SERIAL_SUB_SAT_EN
        issue(8'h00, 8'h01, 8'h00, 1'b1, 1'b1, k);
`else
        issue(8'h00, 8'h01, 8'hFF, 1'b1, 1'b1, k);
`endif
        drain();

        // start and operand changes during RUN are ignored
        issue(8'h09, 8'h04, 8'h05, 1'b0, 1'b1, k);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h01;
        bus.b = 8'h02;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 8'hAA;
        bus.b = 8'h55;
        drain();
        repeat (12) @(negedge clk);

        // Back-to-back with start held high: results every W+1 cycles
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h80;
        bus.b = 8'h01;
        @(posedge clk);
        #1;
        k = cyc;
        for (int i = 0; i < 3; i++) sb.push_back('{8'h7F, 1'b0, k + W + i * (W + 1)});
        for (int i = 1; i <= 2; i++) begin
            while (cyc < k + i * (W + 1)) @(negedge clk);
            check("b2b_busy_after_done", 32'(bus.busy), 32'd1);
            check("b2b_done_low", 32'(bus.done), 32'd0);
        end
        while (cyc < k + 3 * W + 2) @(negedge clk);
        bus.start = 1'b0;
        drain();
        check("b2b_end_busy", 32'(bus.busy), 32'd0);

        // Reset in RUN cycle 4 aborts without a done pulse
        issue(8'h5A, 8'h23, 8'h00, 1'b0, 1'b0, k);
        while (cyc < k + 4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_diff", 32'(bus.diff), 32'd0);
        check("abort_bout", 32'(bus.bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_no_done_busy", 32'(bus.busy), 32'd0);

        // Normal operation after abort
        issue(8'h5A, 8'h23, 8'h37, 1'b0, 1'b1, k);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
